// File: rtl/ex_muldiv_pkg.sv
// Shared defines for the RV32M multiply/divide unit: widths, funct3 encodings, FSM states.
package ex_muldiv_pkg;

  localparam int unsigned CPU_WIDTH   = 32;
  localparam int unsigned MD_OP_WIDTH = 3;

  typedef enum logic [MD_OP_WIDTH-1:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage handshake between the pipeline and the multiply/divide unit.
interface ex_muldiv_if
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = CPU_WIDTH
) ();

  logic                   start;
  logic [MD_OP_WIDTH-1:0] op;
  logic [XLEN-1:0]        rs1;
  logic [XLEN-1:0]        rs2;
  logic                   flush;
  logic                   stall_req;
  logic                   done;
  logic [XLEN-1:0]        result;

  modport master (
    output start, op, rs1, rs2, flush,
    input  stall_req, done, result
  );

  modport slave (
    input  start, op, rs1, rs2, flush,
    output stall_req, done, result
  );

endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide sharing one
// 2*XLEN accumulator and iteration counter; divide-by-zero/overflow resolve without iterating.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = CPU_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  ex_muldiv_if.slave bus
);

  localparam int unsigned AW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [XLEN-1:0]        opnd_q, opnd_d;
  logic [MD_OP_WIDTH-1:0] op_q, op_d;
  logic                   neg_q, neg_d;
  logic                   spec_q, spec_d;
  logic [XLEN-1:0]        result_q, result_d;
  logic                   done_q, done_d;

  // Decode of the instruction waiting in EX
  logic            s1, s2, neg1, neg2, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag1, mag2, spec_res;

  assign s1   = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                (bus.op == OP_DIV)  || (bus.op == OP_REM);
  assign s2   = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
  assign neg1 = s1 && bus.rs1[XLEN-1];
  assign neg2 = s2 && bus.rs2[XLEN-1];
  assign mag1 = neg1 ? XLEN'(-bus.rs1) : bus.rs1;
  assign mag2 = neg2 ? XLEN'(-bus.rs2) : bus.rs2;

  assign div_zero = bus.op[2] && (bus.rs2 == '0);
  assign div_ovf  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                    (bus.rs1 == MIN_NEG) && (&bus.rs2);
  assign special  = div_zero || div_ovf;

  // op[1] distinguishes remainder from quotient within the divide group
  always_comb begin
    spec_res = '0;
    if (div_zero)     spec_res = bus.op[1] ? bus.rs1 : '1;
    else if (div_ovf) spec_res = bus.op[1] ? '0 : MIN_NEG;
  end

  // One iteration step for each algorithm
  logic [XLEN:0]   mul_sum, div_diff;
  logic [AW-1:0]   mul_step, div_step;

  assign mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, opnd_q};
  assign div_diff = acc_q[AW-2:XLEN-1] - {1'b0, opnd_q};
  assign mul_step = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[AW-1:1]};
  assign div_step = div_diff[XLEN] ? {acc_q[AW-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Sign fix-up and word select once the accumulator holds the magnitude result
  logic [AW-1:0]   prod;
  logic [XLEN-1:0] div_val, final_res;

  assign prod    = neg_q ? AW'(-acc_q) : acc_q;
  assign div_val = op_q[1] ? acc_q[AW-1:XLEN] : acc_q[XLEN-1:0];

  always_comb begin
    final_res = '0;
    if (spec_q)              final_res = acc_q[XLEN-1:0];
    else if (op_q[2])        final_res = neg_q ? XLEN'(-div_val) : div_val;
    else if (op_q == OP_MUL) final_res = prod[XLEN-1:0];
    else                     final_res = prod[AW-1:XLEN];
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    spec_d   = spec_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_CALC;
          op_d    = bus.op;
          neg_d   = bus.op[1] && bus.op[2] ? neg1 : (neg1 ^ neg2);
          spec_d  = special;
          if (special) begin
            cnt_d  = '0;
            acc_d  = {{XLEN{1'b0}}, spec_res};
            opnd_d = '0;
          end else begin
            cnt_d  = CW'(XLEN);
            acc_d  = {{XLEN{1'b0}}, bus.op[2] ? mag1 : mag2};
            opnd_d = bus.op[2] ? mag2 : mag1;
          end
        end
      end
      ST_CALC: begin
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          result_d = final_res;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
          acc_d = op_q[2] ? div_step : mul_step;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      spec_q   <= spec_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Stall holds the pipeline from the issuing cycle through the last iteration
  assign bus.stall_req = rst_n && (((state_q == ST_IDLE) && bus.start && !bus.flush) ||
                                   (state_q == ST_CALC));
  assign bus.done      = done_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed and randomized checks of ex_muldiv with a result scoreboard.
module tb_ex_muldiv;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] sb_q[$];

  ex_muldiv_if #(.XLEN(32)) bus ();
  ex_muldiv #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ref_md = '0;
    case (op)
      3'd0: begin up = ua * ub; ref_md = up[31:0]; end
      3'd1: begin sp = sa * sb; ref_md = sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); ref_md = sp[63:32]; end
      3'd3: begin up = ua * ub; ref_md = up[63:32]; end
      3'd4: ref_md = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: ref_md = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: ref_md = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: ref_md = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return op[2] && ((b == 0) || ((op == 3'd4 || op == 3'd6) &&
                     a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one op, wait for done (bounded), compare latency/stall/result/pulse width
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit hold);
    int          lat;
    int          stalls;
    bit          got;
    logic [31:0] want;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs1   = a;
    bus.rs2   = b;
    sb_q.push_back(exp);
    #1 chk({tag, "_stall_issue"}, bus.stall_req, 1);
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    bus.rs1 = $urandom;
    bus.rs2 = $urandom;
    lat = 0; stalls = 0; got = 0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (bus.stall_req) stalls++;
      if (bus.done) got = 1;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_stall_cycles"}, stalls, exp_lat - 1);
    want = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
    if (got) chk({tag, "_result"}, bus.result, want);
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, bus.done, 0);
    chk({tag, "_result_hold"}, bus.result, exp);
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          pulses;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.rs1 = '0; bus.rs2 = '0; bus.flush = 1'b0;
    #1;
    chk("rst_done", bus.done, 0);
    chk("rst_stall", bus.stall_req, 0);
    chk("rst_result", bus.result, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_7_m3",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    run_op("mulhu_max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    run_op("mulh_m1",     3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
    run_op("mulhsu_m1",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
    run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 0);
    run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 0);
    run_op("divu_100_7",  3'd5, 32'd100,        32'd7,         32'd14,        34, 0);
    run_op("remu_100_7",  3'd7, 32'd100,        32'd7,         32'd2,         34, 0);
    run_op("divu_by0",    3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 2,  0);
    run_op("rem_by0",     3'd6, 32'd5,          32'd0,         32'd5,         2,  0);
    run_op("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2,  0);
    run_op("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2,  0);

    // Flush on the 10th CALC cycle aborts without a done pulse
    @(negedge clk);
    prev = bus.result;
    bus.start = 1'b1; bus.op = 3'd0; bus.rs1 = 32'd3; bus.rs2 = 32'd5;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_stall", bus.stall_req, 0);
    chk("flush_done", bus.done, 0);
    chk("flush_result_kept", bus.result, prev);
    pulses = 0;
    repeat (40) begin @(negedge clk); if (bus.done) pulses++; end
    chk("flush_no_done", pulses, 0);
    run_op("after_flush", 3'd0, 32'd3, 32'd5, 32'd15, 34, 0);

    // Flush together with start in IDLE must not launch
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd5; bus.rs1 = 32'd9; bus.rs2 = 32'd0;
    #1 chk("flush_start_stall", bus.stall_req, 0);
    @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
    pulses = 0;
    repeat (5) begin @(negedge clk); if (bus.done || bus.stall_req) pulses++; end
    chk("flush_start_idle", pulses, 0);

    // Reset on the 5th CALC cycle clears outputs at once and discards the op
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd5; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_done", bus.done, 0);
    chk("midrst_stall", bus.stall_req, 0);
    chk("midrst_result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin @(negedge clk); if (bus.done) pulses++; end
    chk("midrst_no_done", pulses, 0);

    // start held through DONE gives a single pulse
    run_op("hold_start", 3'd7, 32'd1000, 32'd3, 32'd1, 34, 1);
    pulses = 0;
    repeat (40) begin @(negedge clk); if (bus.done) pulses++; end
    chk("hold_no_repeat", pulses, 0);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if (i == 2) begin rop = 3'd4; rb = 32'd0; end
      if (i == 5) begin rop = 3'd6; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (i == 6) begin rop = 3'd2; ra[31] = 1'b1; rb[31] = 1'b1; end
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, ref_md(rop, ra, rb),
             is_special(rop, ra, rb) ? 2 : 34, 0);
    end

    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
